csa_8: RTL and testbench
========================

CSA_8 -- requirements
Module: csa_8

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The block SHALL have no parameters; width is fixed at 8 bits.
REQ-003 Port `clk`: input, 1 bit, rising-edge clock for all state.
REQ-004 Port `rst`: input, 1 bit, asynchronous active-high reset.
REQ-005 Port `A`: input, 8 bits, addend A (unsigned; two's complement for the overflow feature).
REQ-006 Port `B`: input, 8 bits, addend B.
REQ-007 Port `CIN`: input, 1 bit, carry-in.
REQ-008 Port `SUM`: output, 8 bits, registered sum bits [7:0].
REQ-009 Port `CARRY`: output, 1 bit, registered carry-out (bit 8 of the sum).
REQ-010 Port order SHALL be `clk`, `rst`, `A`, `B`, `CIN`, `SUM`, `CARRY`, followed by `OVF` when configured.

Function
REQ-011 The combinational result SHALL be {CARRY,SUM} = A + B + CIN, a full 9-bit result with no truncation.
REQ-012 Carry-select structure:
- Lower nibble [3:0]: one 4-bit ripple-carry adder built from full-adder cells, with carry-in `CIN`.
- Upper nibble [7:4]: two 4-bit ripple adders, one with carry-in 0 and one with carry-in 1.
REQ-013 The lower-nibble carry-out SHALL select, via 2:1 muxes, the upper sum nibble and the final carry from the matching upper adder.
REQ-014 Full-adder cell equations: s = a^b^c, co = ab|ac|bc.
- No behavioural `+` is allowed inside the datapath.
REQ-015 `SUM` and `CARRY` SHALL be registered on the rising edge of `clk`.
- Latency: exactly 1 cycle from inputs sampled at edge N to outputs valid after edge N.
REQ-016 A new operand set SHALL be accepted every cycle; there is no handshake and no stall.
REQ-017 Inputs changing between clock edges SHALL have no effect on the outputs until the next rising edge.
REQ-018 Wrap-around: on a carry out of bit 7, SUM holds the low 8 bits and CARRY is 1 (e.g. FF+00+1 gives SUM=00, CARRY=1).

Reset
REQ-019 While `rst`=1, `SUM`=8'h00, `CARRY`=0, and `OVF`=0 (when present), immediately and independent of `clk`.
REQ-020 On release of reset, the first register update SHALL occur at the next rising `clk` edge, using the inputs sampled at that edge.
REQ-021 Reset asserted mid-stream SHALL discard the in-flight result.
- No stale value may appear after reset is released.

Configuration
REQ-022 Macro `CSA8_OVF_EN` defined: the block SHALL add port `OVF` (output, 1 bit), placed after `CARRY`.
- `OVF` is registered with the same 1-cycle latency as `SUM`.
- `OVF` = signed two's-complement overflow = carry into bit 7 XOR carry out of bit 7.
REQ-023 Macro `CSA8_OVF_EN` undefined: the `OVF` port and its logic SHALL be absent, and all other behaviour is identical.

Verification
REQ-024 Reset behaviour: assert `rst` with A=FF, B=FF, CIN=1 -> SUM=00, CARRY=0 while reset is held.
- After release, the next edge gives SUM=FF, CARRY=1.
REQ-025 Directed vectors, with CIN=0 and results checked one cycle after each input set:
- 00+01 -> SUM=01, CARRY=0
- 77+55 -> SUM=CC, CARRY=0
- 56+61 -> SUM=B7, CARRY=0
REQ-026 Carry-out vectors, with CIN=0:
- EA+D5 -> SUM=BF, CARRY=1
- 85+FF -> SUM=84, CARRY=1
REQ-027 Carry-select path, both mux branches:
- 0F+00, CIN=1 -> SUM=10, CARRY=0 (lower carry selects the carry-in-1 adder)
- F0+0F, CIN=0 -> SUM=FF, CARRY=0
- FF+00, CIN=1 -> SUM=00, CARRY=1
REQ-028 With `CSA8_OVF_EN` defined:
- 77+55 -> OVF=1
- EA+D5 -> OVF=0
- 80+80 -> SUM=00, CARRY=1, OVF=1
REQ-029 Back-to-back inputs changing every cycle SHALL produce matching results on consecutive cycles.
- A randomized run of 1000 vectors, compared against a 9-bit reference sum, SHALL show zero mismatches.

Source files
------------

// File: rtl/csa_8.sv
// csa_8: 8-bit registered carry-select adder, {CARRY,SUM} = A + B + CIN.
// Define CSA8_OVF_EN to add the registered signed-overflow output OVF.

module csa8_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);
endmodule

module csa8_rca4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       co_o
);
    logic [4:0] c;

    assign c[0] = c_i;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        csa8_fa u_fa (
            .a_i  (a_i[i]),
            .b_i  (b_i[i]),
            .c_i  (c[i]),
            .s_o  (s_o[i]),
            .co_o (c[i+1])
        );
    end

    assign co_o = c[4];
endmodule

module csa_8 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       CIN,
    output logic [7:0] SUM,
    output logic       CARRY
`ifdef CSA8_OVF_EN
    ,
    output logic       OVF
`endif
);
    logic [3:0] lo_s;
    logic       lo_c;
    logic [3:0] hi0_s;
    logic       hi0_c;
    logic [3:0] hi1_s;
    logic       hi1_c;

    logic [7:0] sum_d;
    logic [7:0] sum_q;
    logic       carry_d;
    logic       carry_q;

    csa8_rca4 u_lo (
        .a_i  (A[3:0]),
        .b_i  (B[3:0]),
        .c_i  (CIN),
        .s_o  (lo_s),
        .co_o (lo_c)
    );

    // Upper nibble computed speculatively for both possible carry-ins.
    csa8_rca4 u_hi0 (
        .a_i  (A[7:4]),
        .b_i  (B[7:4]),
        .c_i  (1'b0),
        .s_o  (hi0_s),
        .co_o (hi0_c)
    );

    csa8_rca4 u_hi1 (
        .a_i  (A[7:4]),
        .b_i  (B[7:4]),
        .c_i  (1'b1),
        .s_o  (hi1_s),
        .co_o (hi1_c)
    );

    // Lower-nibble carry picks the matching upper adder result.
    always_comb begin
        sum_d[3:0] = lo_s;
        sum_d[7:4] = lo_c ? hi1_s : hi0_s;
        carry_d    = lo_c ? hi1_c : hi0_c;
    end

    // Result register, cleared immediately by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q   <= 8'h00;
            carry_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign SUM   = sum_q;
    assign CARRY = carry_q;

`ifdef CSA8_OVF_EN
    logic c7_in;
    logic ovf_d;
    logic ovf_q;

    // Carry into bit 7 is recovered from that bit's sum and operands.
    always_comb begin
        c7_in = sum_d[7] ^ A[7] ^ B[7];
        ovf_d = c7_in ^ carry_d;
    end

    // Overflow register, same latency as the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign OVF = ovf_q;
`endif

endmodule

// File: tb/tb_csa_8.sv
// tb_csa_8: self-checking bench for csa_8 with a plain-arithmetic reference.
// Covers reset, directed vectors, carry-select paths and random streams.

module tb_csa_8;
    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       CIN;
    logic [7:0] SUM;
    logic       CARRY;
`ifdef CSA8_OVF_EN
    logic       OVF;
`endif

    int checks = 0;
    int errors = 0;

    csa_8 dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .CIN   (CIN),
        .SUM   (SUM),
        .CARRY (CARRY)
`ifdef CSA8_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ref_sum(input logic [7:0] a,
                                           input logic [7:0] b,
                                           input logic c);
        int unsigned t;
        t = int'(a) + int'(b) + int'(c);
        return t[8:0];
    endfunction

    function automatic logic ref_ovf(input logic [7:0] a,
                                     input logic [7:0] b,
                                     input logic c);
        int s;
        s = int'($signed(a)) + int'($signed(b)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    // Drive at negedge, sample 1 time unit after the following posedge.
    task automatic apply(input logic [7:0] a, input logic [7:0] b,
                         input logic c);
        @(negedge clk);
        A   = a;
        B   = b;
        CIN = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [7:0] a,
                             input logic [7:0] b, input logic c);
        logic [8:0] exp;
        apply(a, b, c);
        exp = ref_sum(a, b, c);
        checks++;
        if ({CARRY, SUM} !== exp) begin
            errors++;
            $display("FAIL %s: got CARRY=%0b SUM=%02h, expected CARRY=%0b SUM=%02h",
                     name, CARRY, SUM, exp[8], exp[7:0]);
        end
    endtask

    task automatic test_reset();
        A   = 8'hFF;
        B   = 8'hFF;
        CIN = 1'b1;
        rst = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (SUM !== 8'h00 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: got CARRY=%0b SUM=%02h, expected 0/00",
                     CARRY, SUM);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (SUM !== 8'h00 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got CARRY=%0b SUM=%02h, expected 0/00",
                     CARRY, SUM);
        end
`ifdef CSA8_OVF_EN
        checks++;
        if (OVF !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got OVF=%0b, expected 0", OVF);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (SUM !== 8'h00 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got CARRY=%0b SUM=%02h, expected 0/00",
                     CARRY, SUM);
        end
        @(posedge clk);
        #1;
        checks++;
        if (SUM !== 8'hFF || CARRY !== 1'b1) begin
            errors++;
            $display("FAIL reset_first_edge: got CARRY=%0b SUM=%02h, expected 1/FF",
                     CARRY, SUM);
        end
    endtask

    task automatic test_directed();
        check_vec("dir_00_01", 8'h00, 8'h01, 1'b0);
        checks++;
        if (SUM !== 8'h01 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL dir_00_01_const: got %0b/%02h, expected 0/01", CARRY, SUM);
        end
        check_vec("dir_77_55", 8'h77, 8'h55, 1'b0);
        checks++;
        if (SUM !== 8'hCC || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL dir_77_55_const: got %0b/%02h, expected 0/CC", CARRY, SUM);
        end
        check_vec("dir_56_61", 8'h56, 8'h61, 1'b0);
        checks++;
        if (SUM !== 8'hB7 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL dir_56_61_const: got %0b/%02h, expected 0/B7", CARRY, SUM);
        end
    endtask

    task automatic test_carry_out();
        check_vec("co_EA_D5", 8'hEA, 8'hD5, 1'b0);
        checks++;
        if (SUM !== 8'hBF || CARRY !== 1'b1) begin
            errors++;
            $display("FAIL co_EA_D5_const: got %0b/%02h, expected 1/BF", CARRY, SUM);
        end
        check_vec("co_85_FF", 8'h85, 8'hFF, 1'b0);
        checks++;
        if (SUM !== 8'h84 || CARRY !== 1'b1) begin
            errors++;
            $display("FAIL co_85_FF_const: got %0b/%02h, expected 1/84", CARRY, SUM);
        end
    endtask

    task automatic test_carry_select();
        check_vec("sel_0F_00_c1", 8'h0F, 8'h00, 1'b1);
        checks++;
        if (SUM !== 8'h10 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL sel_0F_00_const: got %0b/%02h, expected 0/10", CARRY, SUM);
        end
        check_vec("sel_F0_0F_c0", 8'hF0, 8'h0F, 1'b0);
        checks++;
        if (SUM !== 8'hFF || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL sel_F0_0F_const: got %0b/%02h, expected 0/FF", CARRY, SUM);
        end
        check_vec("sel_FF_00_c1", 8'hFF, 8'h00, 1'b1);
        checks++;
        if (SUM !== 8'h00 || CARRY !== 1'b1) begin
            errors++;
            $display("FAIL sel_FF_00_const: got %0b/%02h, expected 1/00", CARRY, SUM);
        end
    endtask

`ifdef CSA8_OVF_EN
    task automatic test_ovf();
        logic [7:0] va [3] = '{8'h77, 8'hEA, 8'h80};
        logic [7:0] vb [3] = '{8'h55, 8'hD5, 8'h80};
        logic       eo [3] = '{1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            check_vec("ovf_sum", va[i], vb[i], 1'b0);
            checks++;
            if (OVF !== eo[i] || OVF !== ref_ovf(va[i], vb[i], 1'b0)) begin
                errors++;
                $display("FAIL ovf_%02h_%02h: got OVF=%0b, expected %0b",
                         va[i], vb[i], OVF, eo[i]);
            end
        end
        checks++;
        if (SUM !== 8'h00 || CARRY !== 1'b1) begin
            errors++;
            $display("FAIL ovf_80_80: got %0b/%02h, expected 1/00", CARRY, SUM);
        end
    endtask
`endif

    // Inputs wiggling between edges must not reach the outputs.
    task automatic test_hold();
        check_vec("hold_base", 8'h12, 8'h34, 1'b0);
        #1;
        A   = 8'hFF;
        B   = 8'hFF;
        CIN = 1'b1;
        #2;
        checks++;
        if (SUM !== 8'h46 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL hold_midcycle: got %0b/%02h, expected 0/46", CARRY, SUM);
        end
    endtask

    task automatic test_mid_reset();
        check_vec("midrst_pre", 8'hC3, 8'h5A, 1'b1);
        A   = 8'h99;
        B   = 8'h88;
        CIN = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (SUM !== 8'h00 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL midrst_clear: got %0b/%02h, expected 0/00", CARRY, SUM);
        end
        @(posedge clk);
        #1;
        checks++;
        if (SUM !== 8'h00 || CARRY !== 1'b0) begin
            errors++;
            $display("FAIL midrst_held: got %0b/%02h, expected 0/00", CARRY, SUM);
        end
        @(negedge clk);
        rst = 1'b0;
        check_vec("midrst_post", 8'h01, 8'h02, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] qa [$];
        logic [7:0] qb [$];
        logic       qc [$];
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] exp;
        @(negedge clk);
        for (int i = 0; i <= 1000; i++) begin
            if (i < 1000) begin
                a = 8'($urandom);
                b = 8'($urandom);
                c = 1'($urandom);
                A   = a;
                B   = b;
                CIN = c;
                qa.push_back(a);
                qb.push_back(b);
                qc.push_back(c);
            end
            @(posedge clk);
            #1;
            if (qa.size() > 0) begin
                a = qa.pop_front();
                b = qb.pop_front();
                c = qc.pop_front();
                exp = ref_sum(a, b, c);
                checks++;
                if ({CARRY, SUM} !== exp) begin
                    errors++;
                    $display("FAIL b2b[%0d] %02h+%02h+%0b: got %0b/%02h, expected %0b/%02h",
                             i, a, b, c, CARRY, SUM, exp[8], exp[7:0]);
                end
`ifdef CSA8_OVF_EN
                checks++;
                if (OVF !== ref_ovf(a, b, c)) begin
                    errors++;
                    $display("FAIL b2b_ovf[%0d] %02h+%02h+%0b: got %0b, expected %0b",
                             i, a, b, c, OVF, ref_ovf(a, b, c));
                end
`endif
            end
            @(negedge clk);
        end
    endtask

    initial begin
        A   = 8'h00;
        B   = 8'h00;
        CIN = 1'b0;
        rst = 1'b1;
        test_reset();
        test_directed();
        test_carry_out();
        test_carry_select();
`ifdef CSA8_OVF_EN
        test_ovf();
`endif
        test_hold();
        test_mid_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
